// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART TX arbiter types and constants: FSM state encoding,
// default requester count and the round-robin successor helper.
package uart_tx_arbiter_pkg;

    localparam int TX_ARB_NUM_REQ = 3;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BURST    = 2'd1,
        ARB_CFG_WAIT = 2'd2,
        ARB_CFG_REQ  = 2'd3
    } tx_arbiter_fsm_e;

    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte sources, the TX arbiter and the transmitter.
// stall_abort_o exists only when UART_ARB_STALL_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = TX_ARB_NUM_REQ,
    parameter int GNT_W   = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]   req_i;
    logic [8*NUM_REQ-1:0] data_i;
    logic [NUM_REQ-1:0]   last_i;
    logic [NUM_REQ-1:0]   ack_o;
    logic [7:0]           tx_data_o;
    logic                 tx_fifo_write_o;
    logic                 tx_fifo_full_i;
    logic                 tx_fifo_empty_i;
    logic                 tx_idle_i;
    logic                 cfg_start_i;
    logic                 config_req_mst_o;
    logic                 req_done_i;
    logic                 cfg_busy_o;
    logic [GNT_W-1:0]     grant_o;
`ifdef UART_ARB_STALL_TIMEOUT_EN
    logic                 stall_abort_o;
`endif

    // The arbiter itself uses the slave view; sources/transmitter use master.
    modport slave (
        input  req_i, data_i, last_i, tx_fifo_full_i, tx_fifo_empty_i,
               tx_idle_i, cfg_start_i, req_done_i,
        output ack_o, tx_data_o, tx_fifo_write_o, config_req_mst_o,
               cfg_busy_o, grant_o
`ifdef UART_ARB_STALL_TIMEOUT_EN
        , output stall_abort_o
`endif
    );

    modport master (
        output req_i, data_i, last_i, tx_fifo_full_i, tx_fifo_empty_i,
               tx_idle_i, cfg_start_i, req_done_i,
        input  ack_o, tx_data_o, tx_fifo_write_o, config_req_mst_o,
               cfg_busy_o, grant_o
`ifdef UART_ARB_STALL_TIMEOUT_EN
        , input stall_abort_o
`endif
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping cyclically. Shared with the RX-side arbiter.
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = TX_ARB_NUM_REQ,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GNT_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [GNT_W-1:0]   idx_o
);

    int cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = GNT_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter for the UART TX FIFO write port that also
// sequences master config requests. Optional: UART_ARB_STALL_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = TX_ARB_NUM_REQ,
    parameter int GNT_W     = $clog2(NUM_REQ),
    parameter int MAX_STALL = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    uart_tx_arbiter_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_STALL < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and MAX_STALL >= 1");
    end

    tx_arbiter_fsm_e    state_q, state_d;
    logic [GNT_W-1:0]   grant_q, rr_ptr_q, pick_idx, grant_succ;
    logic               pick_found, cfg_pending_q, last_ack, revoke;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         tx_data;
    logic               cfg_req;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_picker (
        .req_i   (bus.req_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_succ = GNT_W'(rr_next_idx(32'(grant_q), NUM_REQ));
    assign last_ack   = (|ack) && bus.last_i[grant_q];

`ifdef UART_ARB_STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(MAX_STALL + 1);
    logic [STALL_W-1:0] stall_cnt_q;
    logic               stall_hit, stall_abort_q;

    // Only cycles where the granted source has nothing to offer count as stall.
    assign stall_hit = (state_q == ARB_BURST) && !bus.req_i[grant_q]
                       && (stall_cnt_q == STALL_W'(MAX_STALL - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q   <= '0;
            stall_abort_q <= 1'b0;
        end else begin
            stall_abort_q <= stall_hit;
            if (state_q != ARB_BURST || (|ack) || stall_hit)
                stall_cnt_q <= '0;
            else if (!bus.req_i[grant_q])
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign revoke            = stall_hit;
    assign bus.stall_abort_o = stall_abort_q;
`else
    assign revoke = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    // A pending configuration always wins re-arbitration, but never cuts a burst.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (cfg_pending_q)
                    state_d = ARB_CFG_WAIT;
                else if (pick_found)
                    state_d = ARB_BURST;
            end
            ARB_BURST: begin
                if (last_ack || revoke)
                    state_d = ARB_IDLE;
            end
            ARB_CFG_WAIT: begin
                if (bus.tx_fifo_empty_i && bus.tx_idle_i)
                    state_d = ARB_CFG_REQ;
            end
            ARB_CFG_REQ: begin
                if (bus.req_done_i)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ack     = '0;
        tx_data = 8'h00;
        cfg_req = (state_q == ARB_CFG_REQ);
        if (state_q == ARB_BURST) begin
            tx_data = bus.data_i[8*grant_q +: 8];
            if (bus.req_i[grant_q] && !bus.tx_fifo_full_i)
                ack[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            cfg_pending_q <= 1'b0;
        end else begin
            if (state_q == ARB_IDLE && !cfg_pending_q && pick_found)
                grant_q <= pick_idx;
            if (last_ack || revoke)
                rr_ptr_q <= grant_succ;
            if (state_q == ARB_CFG_REQ && bus.req_done_i)
                cfg_pending_q <= 1'b0;
            else if (bus.cfg_start_i)
                cfg_pending_q <= 1'b1;
        end
    end

    assign bus.ack_o            = ack;
    assign bus.tx_fifo_write_o  = |ack;
    assign bus.tx_data_o        = tx_data;
    assign bus.config_req_mst_o = cfg_req;
    assign bus.cfg_busy_o       = cfg_pending_q;
    assign bus.grant_o          = grant_q;

endmodule
